// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter owning one shared DATA_W-bit register.
// Define ARB_LOCK_EN to add the LOCK port for back-to-back writes by the owner.
module shared_reg_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int OWN_W  = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
`ifdef ARB_LOCK_EN
  input  logic [N_REQ-1:0]        i_lock,
`endif
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ*DATA_W-1:0] i_data_in,
  output logic [N_REQ-1:0]        o_gnt,
  output logic [DATA_W-1:0]       o_q,
  output logic                    o_q_valid,
  output logic [OWN_W-1:0]        o_owner,
  output logic                    o_wr_done
);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t              r_state;
  state_t              w_state_n;
  logic [OWN_W-1:0]    r_ptr;
  logic [OWN_W-1:0]    w_ptr_n;
  logic [N_REQ-1:0]    r_gnt;
  logic [N_REQ-1:0]    w_gnt_n;
  logic [DATA_W-1:0]   r_q;
  logic [DATA_W-1:0]   w_q_n;
  logic                r_q_valid;
  logic                w_q_valid_n;
  logic [OWN_W-1:0]    r_owner;
  logic [OWN_W-1:0]    w_owner_n;
  logic                r_wr_done;
  logic                w_wr_done_n;

  logic                w_found;
  logic [OWN_W-1:0]    w_winner;
  logic [DATA_W-1:0]   w_slice;
  logic                w_own_req;
  logic                w_hold;

  // First requester at or after PTR, wrapping
  always_comb begin : p_scan
    int v_idx;
    w_found  = 1'b0;
    w_winner = '0;
    v_idx    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      v_idx = int'(r_ptr) + k;
      if (v_idx >= N_REQ) v_idx = v_idx - N_REQ;
      if (!w_found && i_req[v_idx]) begin
        w_found  = 1'b1;
        w_winner = OWN_W'(v_idx);
      end
    end
  end

  assign w_slice   = i_data_in[r_owner*DATA_W +: DATA_W];
  assign w_own_req = i_req[r_owner];

`ifdef ARB_LOCK_EN
  assign w_hold = i_lock[r_owner];
`else
  assign w_hold = 1'b0;
`endif

  always_comb begin
    w_state_n   = r_state;
    w_ptr_n     = r_ptr;
    w_gnt_n     = r_gnt;
    w_q_n       = r_q;
    w_q_valid_n = r_q_valid;
    w_owner_n   = r_owner;
    w_wr_done_n = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_gnt_n   = N_REQ'(1) << w_winner;
          w_owner_n = w_winner;
          w_state_n = S_GRANT;
        end else begin
          w_gnt_n   = '0;
        end
      end
      S_GRANT: begin
        if (w_own_req) begin
          w_q_n       = w_slice;
          w_q_valid_n = 1'b1;
          w_wr_done_n = 1'b1;
        end
        // A locked owner keeps the grant and the pointer
        if (!(w_own_req && w_hold)) begin
          w_gnt_n   = '0;
          w_state_n = S_IDLE;
          w_ptr_n   = (r_owner == OWN_W'(N_REQ - 1)) ?
                      '0 : r_owner + OWN_W'(1);
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_gnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_q       <= '0;
      r_q_valid <= 1'b0;
      r_owner   <= '0;
      r_wr_done <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_ptr     <= w_ptr_n;
      r_gnt     <= w_gnt_n;
      r_q       <= w_q_n;
      r_q_valid <= w_q_valid_n;
      r_owner   <= w_owner_n;
      r_wr_done <= w_wr_done_n;
    end
  end

  assign o_gnt     = r_gnt;
  assign o_q       = r_q;
  assign o_q_valid = r_q_valid;
  assign o_owner   = r_owner;
  assign o_wr_done = r_wr_done;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Scoreboard bench for shared_reg_arbiter: directed vectors, write monitor.
// Define ARB_LOCK_EN to also exercise the LOCK hold path.
module tb_shared_reg_arbiter;

  localparam int N_REQ  = 4;
  localparam int DATA_W = 8;
  localparam int OWN_W  = 2;

  logic                    clk;
  logic                    rst;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] din;
  logic [N_REQ-1:0]        gnt;
  logic [DATA_W-1:0]       q;
  logic                    q_valid;
  logic [OWN_W-1:0]        owner;
  logic                    wr_done;
`ifdef ARB_LOCK_EN
  logic [N_REQ-1:0]        lock;
`endif

  typedef struct packed {
    logic [OWN_W-1:0]  own;
    logic [DATA_W-1:0] dat;
  } wr_t;

  wr_t exp_q[$];
  int  n_pass;
  int  n_total;

  shared_reg_arbiter #(
    .N_REQ (N_REQ),
    .DATA_W(DATA_W),
    .OWN_W (OWN_W)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
`ifdef ARB_LOCK_EN
    .i_lock   (lock),
`endif
    .i_req    (req),
    .i_data_in(din),
    .o_gnt    (gnt),
    .o_q      (q),
    .o_q_valid(q_valid),
    .o_owner  (owner),
    .o_wr_done(wr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_slice(input int i, input logic [DATA_W-1:0] v);
    din[i*DATA_W +: DATA_W] = v;
  endtask

  task automatic push(input int own, input logic [DATA_W-1:0] v);
    wr_t e;
    e.own = OWN_W'(own);
    e.dat = v;
    exp_q.push_back(e);
  endtask

  // Every write pulse must match the oldest expected write
  always @(negedge clk) begin
    if (wr_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {24'h0, q}, 32'hDEAD);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("mon_q", {24'h0, q}, {24'h0, e.dat});
        chk("mon_owner", {30'h0, owner}, {30'h0, e.own});
        chk("mon_q_valid", {31'h0, q_valid}, 32'h1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst = 1'b1;
    req = 4'b1111;
    din = '0;
`ifdef ARB_LOCK_EN
    lock = '0;
`endif
    // Reset dominates pending requests
    cyc();
    cyc();
    chk("rst_gnt", {28'h0, gnt}, 32'h0);
    chk("rst_q", {24'h0, q}, 32'h0);
    chk("rst_q_valid", {31'h0, q_valid}, 32'h0);
    chk("rst_owner", {30'h0, owner}, 32'h0);
    chk("rst_wr_done", {31'h0, wr_done}, 32'h0);
    rst = 1'b0;
    req = 4'b0100;
    set_slice(2, 8'hA5);
    push(2, 8'hA5);
    cyc();
    chk("single_gnt", {28'h0, gnt}, 32'h4);
    chk("single_no_done", {31'h0, wr_done}, 32'h0);
    cyc();
    chk("single_done", {31'h0, wr_done}, 32'h1);
    chk("single_gnt_off", {28'h0, gnt}, 32'h0);
    req = 4'b0000;

    // Rotation from PTR=0 under continuous requests
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < N_REQ; i++) set_slice(i, 8'(8'h10 + i));
    push(0, 8'h10);
    push(1, 8'h11);
    push(2, 8'h12);
    push(3, 8'h13);
    push(0, 8'h10);
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (i % 2 == 0) begin
        chk("rot_gnt", {28'h0, gnt}, 32'(1) << ((i / 2) % 4));
        chk("rot_idle_done", {31'h0, wr_done}, 32'h0);
      end else begin
        chk("rot_write", {31'h0, wr_done}, 32'h1);
      end
    end

    // Abort by requester 1, then wrap scan 2,3,0
    req = 4'b0010;
    cyc();
    chk("abort_gnt", {28'h0, gnt}, 32'h2);
    req = 4'b0000;
    cyc();
    chk("abort_done", {31'h0, wr_done}, 32'h0);
    chk("abort_q", {24'h0, q}, 32'h10);
    chk("abort_owner", {30'h0, owner}, 32'h1);
    chk("abort_gnt_off", {28'h0, gnt}, 32'h0);
    req = 4'b0011;
    set_slice(0, 8'h5A);
    push(0, 8'h5A);
    cyc();
    chk("wrap_gnt", {28'h0, gnt}, 32'h1);
    chk("wrap_owner", {30'h0, owner}, 32'h0);
    cyc();
    chk("wrap_done", {31'h0, wr_done}, 32'h1);
    req = 4'b0000;

    // Reset during requester 3's grant cancels the write
    req = 4'b1000;
    set_slice(3, 8'hFF);
    cyc();
    chk("mid_gnt", {28'h0, gnt}, 32'h8);
    rst = 1'b1;
    cyc();
    chk("mid_gnt_off", {28'h0, gnt}, 32'h0);
    chk("mid_q", {24'h0, q}, 32'h0);
    chk("mid_q_valid", {31'h0, q_valid}, 32'h0);
    chk("mid_owner", {30'h0, owner}, 32'h0);
    chk("mid_done", {31'h0, wr_done}, 32'h0);
    rst = 1'b0;
    req = 4'b0000;
    cyc();
    chk("mid_after_done", {31'h0, wr_done}, 32'h0);

`ifdef ARB_LOCK_EN
    // Locked owner 1 writes back-to-back; requester 0 waits
    req  = 4'b0010;
    lock = 4'b0010;
    set_slice(1, 8'h01);
    set_slice(0, 8'h77);
    push(1, 8'h01);
    push(1, 8'h02);
    push(1, 8'h03);
    push(0, 8'h77);
    cyc();
    chk("lock_gnt0", {28'h0, gnt}, 32'h2);
    req = 4'b0011;
    cyc();
    chk("lock_gnt1", {28'h0, gnt}, 32'h2);
    set_slice(1, 8'h02);
    cyc();
    chk("lock_gnt2", {28'h0, gnt}, 32'h2);
    set_slice(1, 8'h03);
    lock = 4'b0000;
    cyc();
    chk("lock_release", {28'h0, gnt}, 32'h0);
    req = 4'b0001;
    cyc();
    chk("lock_next_gnt", {28'h0, gnt}, 32'h1);
    cyc();
    req = 4'b0000;
`endif

    cyc();
    cyc();
    chk("all_writes_seen", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
